cam_demux_1to8: RTL and testbench

- Registered 1-to-8 demultiplexer: the write-side counterpart of the CAM read-side 8:1 selection path.
- Accepts one data word plus a 3-bit lane select per handshake and steers the word into one of eight per-lane holding registers.
- Each lane presents the word downstream with its own valid/ready handshake.
- Sits between the CAM write/command source and the eight entry-write ports.

---
 rtl/cam_demux_pkg.sv | 35 +++
 rtl/cam_demux_lane.sv | 66 ++++++
 rtl/cam_demux_1to8.sv | 81 ++++++++
 tb/tb_cam_demux_1to8.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_demux_pkg.sv
// Shared definitions for the cam_demux_1to8 block.
// Lane count, select/occupancy widths, lane state encoding and small helpers.
// The lane count is fixed at 8 because the select is 3 bits; other values are unsupported.
package cam_demux_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned OCC_W = 4;

  typedef logic [SEL_W-1:0] lane_sel_t;
  typedef logic [LANES-1:0] lane_mask_t;

  typedef enum logic {
    StEmpty,
    StFull
  } lane_state_e;

  // Number of set bits in a lane mask; result fits 0..8 in OCC_W bits.
  function automatic logic [OCC_W-1:0] popcount(input lane_mask_t mask);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + {{(OCC_W-1){1'b0}}, mask[i]};
    end
    return cnt;
  endfunction

  // One-hot decode of a lane index.
  function automatic lane_mask_t sel_decode(input lane_sel_t sel);
    lane_mask_t one;
    one = {{(LANES-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/cam_demux_lane.sv
// One output lane of cam_demux_1to8: a holding register with EMPTY/FULL state.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - write wdata this cycle (only asserted when the lane can accept)
//   drain       - downstream takes the held word this cycle (valid & ready)
//   wdata       - word to store on load
//   valid       - lane holds a word
//   data        - held word; holds last value while empty
//   parity      - even parity of data (only with CAM_DEMUX_PARITY_EN defined)
module cam_demux_lane
  import cam_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] wdata,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef CAM_DEMUX_PARITY_EN
  ,
  output logic              parity
`endif
);

  lane_state_e state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StEmpty;
      data  <= '0;
`ifdef CAM_DEMUX_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      case (state)
        StEmpty: begin
          if (load) begin
            state <= StFull;
            data  <= wdata;
`ifdef CAM_DEMUX_PARITY_EN
            parity <= ^wdata;
`endif
          end
        end
        StFull: begin
          // A load while full only happens alongside a drain: replace, stay full.
          if (load) begin
            data <= wdata;
`ifdef CAM_DEMUX_PARITY_EN
            parity <= ^wdata;
`endif
          end else if (drain) begin
            state <= StEmpty;
          end
        end
        default: state <= StEmpty;
      endcase
    end
  end

  assign valid = (state == StFull);

endmodule

// File: rtl/cam_demux_1to8.sv
// Registered 1-to-8 demultiplexer feeding the eight CAM entry-write ports.
// One word plus a 3-bit lane select is accepted per handshake and held in that
// lane's register until the lane's own valid/ready handshake drains it.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   in_valid     - upstream word valid
//   in_ready     - selected lane can take a word (depends on in_sel only)
//   in_sel       - target lane 0..7
//   in_data      - word to deliver
//   out_valid    - per-lane valid, bit i = lane i
//   out_ready    - per-lane downstream ready
//   out_data     - lane i in bits [i*DATA_W +: DATA_W]
//   occupancy    - number of lanes holding a word, 0..8
//   out_parity   - per-lane even parity, present only when CAM_DEMUX_PARITY_EN is defined
module cam_demux_1to8
  import cam_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [DATA_W-1:0]       in_data,
  output logic [LANES-1:0]        out_valid,
  input  logic [LANES-1:0]        out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]        occupancy
`ifdef CAM_DEMUX_PARITY_EN
  ,
  output logic [LANES-1:0]        out_parity
`endif
);

  logic             accept;
  lane_mask_t       load;
  lane_mask_t       drain;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // A lane can take a word when empty or when it drains in the same cycle.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign load     = accept ? sel_decode(in_sel) : '0;
  assign drain    = out_valid & out_ready;

  // An accept always adds one; a same-lane drain is already counted in drain.
  always_comb begin
    occ_d = occ_q - popcount(drain) + {{(OCC_W-1){1'b0}}, accept};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cam_demux_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (load[i]),
      .drain  (drain[i]),
      .wdata  (in_data),
      .valid  (out_valid[i]),
      .data   (out_data[i*DATA_W +: DATA_W])
`ifdef CAM_DEMUX_PARITY_EN
      ,
      .parity (out_parity[i])
`endif
    );
  end

endmodule

// File: tb/tb_cam_demux_1to8.sv
// Directed self-checking bench for cam_demux_1to8.
module tb_cam_demux_1to8;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [7:0]  in_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
  logic [3:0]  occupancy;
`ifdef CAM_DEMUX_PARITY_EN
  logic [7:0]  out_parity;
`endif

  int errors = 0;
  int checks = 0;

  cam_demux_1to8 #(
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef CAM_DEMUX_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset === 1'b0 && in_valid === 1'b1) begin
      assert (!$isunknown(in_sel)) else $error("in_sel unknown while in_valid");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] lane(input int i);
    return out_data[i*8 +: 8];
  endfunction

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hFF; out_ready = 8'h00;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("FAIL reset_valid: got %b want 00000000", out_valid);
    end
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL reset_occ: got %0d want 0", occupancy);
    end
    checks++;
    if (out_data !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", out_data);
    end
  endtask

  task automatic test_basic_steer();
    in_sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1; out_ready = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL steer_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'b0010_0000) begin
      errors++; $display("FAIL steer_valid: got %b want 00100000", out_valid);
    end
    checks++;
    if (lane(5) !== 8'hA5) begin
      errors++; $display("FAIL steer_data: got %h want a5", lane(5));
    end
    checks++;
    if (occupancy !== 4'd1) begin
      errors++; $display("FAIL steer_occ: got %0d want 1", occupancy);
    end
  endtask

  task automatic test_backpressure();
    in_sel = 3'd5; in_data = 8'h3C; in_valid = 1'b1; out_ready = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_low: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (lane(5) !== 8'hA5 || out_valid !== 8'b0010_0000 || occupancy !== 4'd1) begin
      errors++;
      $display("FAIL bp_hold: got data=%h valid=%b occ=%0d want a5 00100000 1",
               lane(5), out_valid, occupancy);
    end
    out_ready = 8'b0010_0000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_high: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    checks++;
    if (lane(5) !== 8'h3C || out_valid !== 8'b0010_0000 || occupancy !== 4'd1) begin
      errors++;
      $display("FAIL bp_replace: got data=%h valid=%b occ=%0d want 3c 00100000 1",
               lane(5), out_valid, occupancy);
    end
  endtask

  task automatic test_fill_all();
    // Empty lane 5 first.
    out_ready = 8'b0010_0000;
    tick();
    out_ready = 8'h00;
    checks++;
    if (occupancy !== 4'd0 || out_valid !== 8'h00) begin
      errors++; $display("FAIL drain5: got occ=%0d valid=%b want 0 00000000", occupancy, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i); in_data = 8'h10 + 8'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 4'd8) begin
      errors++; $display("FAIL fill_occ: got %0d want 8", occupancy);
    end
    checks++;
    if (out_valid !== 8'hFF) begin
      errors++; $display("FAIL fill_valid: got %b want 11111111", out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lane(i) !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL fill_data%0d: got %h want %h", i, lane(i), 8'h10 + 8'(i));
      end
    end
    out_ready = 8'b1000_1001;
    tick();
    out_ready = 8'h00;
    checks++;
    if (occupancy !== 4'd5) begin
      errors++; $display("FAIL multi_drain_occ: got %0d want 5", occupancy);
    end
    checks++;
    if (out_valid !== 8'b0111_0110) begin
      errors++; $display("FAIL multi_drain_valid: got %b want 01110110", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1; tick(); reset = 1'b0;
    // Lane 3 full, then accept on lane 0 while lane 3 drains.
    in_sel = 3'd3; in_data = 8'h33; in_valid = 1'b1;
    tick();
    in_sel = 3'd0; in_data = 8'h44; out_ready = 8'b0000_1000;
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'b0000_0001 || occupancy !== 4'd1 || lane(0) !== 8'h44) begin
      errors++;
      $display("FAIL cross_lane: got valid=%b occ=%0d d0=%h want 00000001 1 44",
               out_valid, occupancy, lane(0));
    end
    // Full throughput on lane 0 while it drains every cycle.
    out_ready = 8'b0000_0001; in_valid = 1'b1; in_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h51 + 8'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if (lane(0) !== 8'h51 + 8'(i) || occupancy !== 4'd1 || out_valid !== 8'b0000_0001) begin
        errors++;
        $display("FAIL b2b_word%0d: got d=%h occ=%0d valid=%b want %h 1 00000001",
                 i, lane(0), occupancy, out_valid, 8'h51 + 8'(i));
      end
    end
    in_valid = 1'b0; out_ready = 8'h00;
  endtask

  task automatic test_mid_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    in_valid = 1'b1; in_sel = 3'd2; in_data = 8'h22;
    tick();
    in_sel = 3'd6; in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'b0100_0100 || occupancy !== 4'd2) begin
      errors++; $display("FAIL pre_reset: got valid=%b occ=%0d want 01000100 2", out_valid, occupancy);
    end
    reset = 1'b1; in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h99;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h00 || occupancy !== 4'd0) begin
      errors++; $display("FAIL mid_reset: got valid=%b occ=%0d want 00000000 0", out_valid, occupancy);
    end
    checks++;
    if (lane(4) !== 8'h00) begin
      errors++; $display("FAIL mid_reset_lane4: got %h want 00", lane(4));
    end
  endtask

`ifdef CAM_DEMUX_PARITY_EN
  task automatic test_parity();
    in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h07;
    tick();
    in_sel = 3'd2; in_data = 8'h03;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_parity[1] !== 1'b1) begin
      errors++; $display("FAIL parity1: got %b want 1", out_parity[1]);
    end
    checks++;
    if (out_parity[2] !== 1'b0) begin
      errors++; $display("FAIL parity2: got %b want 0", out_parity[2]);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 8'h00;
    test_reset();
    test_basic_steer();
    test_backpressure();
    test_fill_all();
    test_back_to_back();
    test_mid_reset();
`ifdef CAM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
